// File: rtl/sweep_pkg.sv
// Shared encodings and helpers for the truth-table sweeper block.
// Holds the state enum, the vector count and the first-mismatch finder.
package sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Lowest set bit position; zero when no bit is set.
    function automatic logic [IDX_W-1:0] lowestSetIdx(input logic [NUM_VECTORS-1:0] diff);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (diff[i]) pos = IDX_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper and its controller: sweep control, F feedback,
// the golden mask, the A/B/C drive and the captured result.
interface truth_table_sweeper_if;
    import sweep_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   f_in;
    logic [NUM_VECTORS-1:0] expected;
    logic                   a_out;
    logic                   b_out;
    logic                   c_out;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] result;
    logic                   mismatch;
    logic [IDX_W-1:0]       err_idx;

    modport master (
        output start, abort, f_in, expected,
        input  a_out, b_out, c_out, busy, done, result, mismatch, err_idx
    );

    modport slave (
        input  start, abort, f_in, expected,
        output a_out, b_out, c_out, busy, done, result, mismatch, err_idx
    );

endinterface

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Down-counter that times how long each input vector is held.
// Reloads to DWELL_CYCLES-1 on load; expire is high while the count sits at zero.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps A/B/C through 000..111, holds each vector for DWELL_CYCLES, captures F
// into a truth table and flags the lowest index that differs from the golden mask.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int DWELL_CYCLES = 50,
    parameter int CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sweeper_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_VECTORS-1:0] result_q, result_d;
    logic                   mismatch_q, mismatch_d;
    logic [IDX_W-1:0]       errIdx_q, errIdx_d;
    logic [IDX_W-1:0]       vec_q, vec_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic timerLoad;
    logic timerEnable;
    logic timerExpire;

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timerLoad),
        .enable (timerEnable),
        .expire (timerExpire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        result_d    = result_q;
        mismatch_d  = mismatch_q;
        errIdx_d    = errIdx_q;
        timerLoad   = 1'b0;
        timerEnable = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Abort dominates start; leaving DONE also drops the verdict.
                if (bus.abort) begin
                    state_d    = ST_IDLE;
                    mismatch_d = 1'b0;
                    errIdx_d   = '0;
                end else if (bus.start) begin
                    state_d    = ST_DRIVE;
                    idx_d      = '0;
                    result_d   = '0;
                    mismatch_d = 1'b0;
                    errIdx_d   = '0;
                    timerLoad  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    timerEnable = 1'b1;
                    if (timerExpire) begin
                        result_d[idx_q] = bus.f_in;
                        // The verdict uses the table including the bit captured on this edge.
                        if (idx_q == LAST_IDX) begin
                            state_d    = ST_DONE;
                            idx_d      = '0;
                            mismatch_d = |(result_d ^ bus.expected);
                            errIdx_d   = lowestSetIdx(result_d ^ bus.expected);
                        end else begin
                            idx_d     = idx_q + IDX_W'(1);
                            timerLoad = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vec_d  = (state_d == ST_DRIVE) ? idx_d : '0;
        busy_d = (state_d == ST_DRIVE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            result_q   <= '0;
            mismatch_q <= 1'b0;
            errIdx_q   <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            mismatch_q <= mismatch_d;
            errIdx_q   <= errIdx_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.a_out    = vec_q[2];
    assign bus.b_out    = vec_q[1];
    assign bus.c_out    = vec_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.mismatch = mismatch_q;
    assign bus.err_idx  = errIdx_q;

endmodule
